bus_uart_tx: RTL and testbench

Memory-mapped UART transmitter attached to the core's data bus, downstream of `riscv_core`'s `bus_*` outputs. Software stores bytes to a TX data register. They queue in a small FIFO and shift out as 8N1 frames on a serial line. A status register reports FIFO and transmitter state. It is the first console peripheral on the pipelined core's data bus.

---
 rtl/bus_uart_tx.sv | 105 ++++++++++
 tb/tb_bus_uart_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO and a status register
module bus_uart_tx #(
    parameter logic [31:0] BASE_ADDRESS   = 32'h8000_0000,
    parameter int          CLOCKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    output logic [31:0] bus_read_data,
    input  logic [31:0] bus_write_data,
    input  logic [3:0]  bus_byte_enable,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    output logic        uart_tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
    localparam logic [15:0] BIT_LAST = 16'(CLOCKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          sel, wr_data, clr_ovf, deq, accept, unused;
    logic [31:0]   status;

    assign sel     = bus_address[31:3] == BASE_ADDRESS[31:3];
    assign wr_data = sel && bus_write_enable && !bus_address[2] && bus_byte_enable[0];
    assign clr_ovf = sel && bus_write_enable && bus_address[2] && bus_byte_enable[0] && bus_write_data[3];
    assign deq     = state == IDLE && count != '0;
    // a full FIFO still takes a byte when the head leaves in the same cycle
    assign accept  = wr_data && (count != DEPTH || deq);
    assign status  = {16'h0, 8'(count), 4'h0, overflow, state != IDLE, count == '0, count == DEPTH};
    assign unused  = ^{bus_address[1:0], bus_write_data[31:8], bus_byte_enable[3:1]};

    // FIFO storage; pointers and count alone define what is valid, so no reset needed
    always_ff @(posedge clock)
        if (accept) mem[wr_ptr] <= bus_write_data[7:0];

    // FIFO bookkeeping and sticky overflow (a drop beats a same-cycle clear)
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            count    <= count + CW'(accept) - CW'(deq);
            overflow <= (wr_data && !accept) ? 1'b1 : clr_ovf ? 1'b0 : overflow;
        end

    // transmit FSM; uart_tx is registered alongside each state change
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            case (state)
                IDLE:
                    if (deq) begin
                        shift   <= mem[rd_ptr];
                        baud    <= BIT_LAST;
                        state   <= START;
                        uart_tx <= 1'b0;
                    end
                START:
                    if (baud == '0) begin
                        baud    <= BIT_LAST;
                        bit_idx <= '0;
                        state   <= DATA;
                        uart_tx <= shift[0];
                    end else baud <= baud - 1'b1;
                DATA:
                    if (baud == '0) begin
                        baud    <= BIT_LAST;
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        state   <= bit_idx == 3'd7 ? STOP : DATA;
                        uart_tx <= bit_idx == 3'd7 ? 1'b1 : shift[1];
                    end else baud <= baud - 1'b1;
                STOP:
                    if (baud == '0) state <= IDLE;
                    else baud <= baud - 1'b1;
                default: state <= IDLE;
            endcase
        end

    // registered read port; status reflects the state before this cycle's updates
    always_ff @(posedge clock or negedge reset)
        if (!reset) bus_read_data <= '0;
        else bus_read_data <= (sel && bus_read_enable && bus_address[2]) ? status : '0;
endmodule

// File: tb/tb_bus_uart_tx.sv
// tb_bus_uart_tx: scoreboard bench for bus_uart_tx with a serial frame monitor
module tb_bus_uart_tx;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int CPB = 4;

    logic        clock, reset;
    logic [31:0] bus_address, bus_read_data, bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable, bus_write_enable, uart_tx;

    int checks = 0, errors = 0, cyc = 0;
    int frames_seen = 0, frames_done = 0;
    int prev_start = 0, last_start = 0, last_end = 0;
    logic [7:0] sb [$];

    bus_uart_tx #(.BASE_ADDRESS(BASE), .CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .bus_address(bus_address),
        .bus_read_data(bus_read_data), .bus_write_data(bus_write_data),
        .bus_byte_enable(bus_byte_enable), .bus_read_enable(bus_read_enable),
        .bus_write_enable(bus_write_enable), .uart_tx(uart_tx)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // serial monitor: samples every cycle of a frame, checks bit timing, pops the scoreboard
    initial begin
        logic [39:0] s;
        logic [7:0] got, exp;
        bit ab, shape_ok;
        int start_c;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && uart_tx === 1'b0) begin
                frames_seen++;
                start_c = cyc;
                s = '0;
                s[0] = uart_tx;
                ab = 0;
                for (int i = 1; i < 40; i++) begin
                    @(negedge clock);
                    if (reset !== 1'b1) begin
                        ab = 1;
                        break;
                    end
                    s[i] = uart_tx;
                end
                if (!ab) begin
                    shape_ok = (s[0] === 1'b0) && (s[36] === 1'b1);
                    for (int g = 0; g < 10; g++)
                        for (int k = 1; k < CPB; k++)
                            if (s[g*CPB+k] !== s[g*CPB]) shape_ok = 0;
                    for (int b = 0; b < 8; b++) got[b] = s[(b+1)*CPB];
                    checks++;
                    if (!shape_ok) begin
                        errors++;
                        $display("FAIL frame_shape: samples %b not start/8 data/stop held %0d cycles each", s, CPB);
                    end
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL frame_data: got byte %h, expected no frame", got);
                    end else begin
                        exp = sb.pop_front();
                        if (got !== exp) begin
                            errors++;
                            $display("FAIL frame_data: got byte %h expected %h", got, exp);
                        end
                    end
                    prev_start = last_start;
                    last_start = start_c;
                    last_end = cyc;
                    frames_done++;
                end
            end
        end
    end

    task automatic bus_idle();
        bus_address = '0;
        bus_write_data = '0;
        bus_byte_enable = '0;
        bus_read_enable = 0;
        bus_write_enable = 0;
    endtask

    task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clock);
        bus_address = a;
        bus_write_data = d;
        bus_byte_enable = b;
        bus_write_enable = 1;
        bus_read_enable = 0;
    endtask

    task automatic bus_release();
        @(negedge clock);
        bus_idle();
    endtask

    task automatic test_reset();
        bus_idle();
        reset = 1;
        #2 reset = 0;
        repeat (3) @(negedge clock);
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
        checks++;
        if (bus_read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus_read_data); end
        reset = 1;
        @(negedge clock);
        bus_address = BASE + 4;
        bus_read_enable = 1;
        @(negedge clock);
        bus_idle();
        checks++;
        if (bus_read_data !== 32'h2) begin errors++; $display("FAIL reset_status: got %h expected 00000002", bus_read_data); end
        @(negedge clock);
        checks++;
        if (bus_read_data !== 32'h0) begin errors++; $display("FAIL idle_rdata: got %h expected 0", bus_read_data); end
    endtask

    task automatic test_single_byte();
        logic exp_busy;
        drive_write(BASE, 32'hA5, 4'b0001);
        sb.push_back(8'hA5);
        @(negedge clock);
        bus_idle();
        bus_address = BASE + 4;
        bus_read_enable = 1;
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL latency_early: got tx %b expected 1", uart_tx); end
        for (int n = 2; n <= 43; n++) begin
            @(negedge clock);
            if (n == 2) begin
                checks++;
                if (uart_tx !== 1'b0) begin errors++; $display("FAIL latency_start: got tx %b expected 0", uart_tx); end
                checks++;
                if (bus_read_data !== 32'h100) begin errors++; $display("FAIL status_pre_deq: got %h expected 00000100", bus_read_data); end
            end else begin
                exp_busy = n <= 42;
                checks++;
                if (bus_read_data[2] !== exp_busy) begin errors++; $display("FAIL busy_n%0d: got %b expected %b", n, bus_read_data[2], exp_busy); end
            end
        end
        checks++;
        if (bus_read_data !== 32'h2) begin errors++; $display("FAIL status_after_frame: got %h expected 00000002", bus_read_data); end
        bus_idle();
    endtask

    task automatic test_overflow();
        int target;
        target = frames_done + 5;
        for (int i = 0; i < 6; i++) begin
            drive_write(BASE, 32'(8'h11 * (i + 1)), 4'b0001);
            if (i < 5) sb.push_back(8'(8'h11 * (i + 1)));
        end
        @(negedge clock);
        bus_idle();
        bus_address = BASE + 4;
        bus_read_enable = 1;
        @(negedge clock);
        checks++;
        if (bus_read_data !== 32'h40D) begin errors++; $display("FAIL overflow_status: got %h expected 0000040D", bus_read_data); end
        bus_write_enable = 1;
        bus_byte_enable = 4'b0001;
        bus_write_data = 32'h8;
        @(negedge clock);
        bus_write_enable = 0;
        checks++;
        if (bus_read_data !== 32'h40D) begin errors++; $display("FAIL read_before_clear: got %h expected 0000040D", bus_read_data); end
        @(negedge clock);
        checks++;
        if (bus_read_data !== 32'h405) begin errors++; $display("FAIL overflow_cleared: got %h expected 00000405", bus_read_data); end
        bus_idle();
        for (int i = 0; i < 400 && frames_done < target; i++) @(negedge clock);
        checks++;
        if (frames_done !== target) begin errors++; $display("FAIL overflow_drain: got %0d frames expected %0d", frames_done, target); end
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL overflow_pending: got %0d bytes left expected 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        int target;
        target = frames_done + 2;
        drive_write(BASE, 32'h00, 4'b0001);
        sb.push_back(8'h00);
        drive_write(BASE, 32'hFF, 4'b0001);
        sb.push_back(8'hFF);
        bus_release();
        for (int i = 0; i < 250 && frames_done < target; i++) @(negedge clock);
        checks++;
        if (frames_done !== target) begin errors++; $display("FAIL b2b_frames: got %0d expected %0d", frames_done, target); end
        checks++;
        if (last_start - prev_start !== 10 * CPB + 1) begin errors++; $display("FAIL b2b_gap: got %0d expected %0d", last_start - prev_start, 10 * CPB + 1); end
        checks++;
        if (last_end - prev_start + 1 !== 20 * CPB + 1) begin errors++; $display("FAIL b2b_span: got %0d expected %0d", last_end - prev_start + 1, 20 * CPB + 1); end
    endtask

    task automatic test_decode();
        int base;
        base = frames_seen;
        drive_write(BASE + 8, 32'h55, 4'b1111);
        drive_write(BASE, 32'h55, 4'b1110);
        @(negedge clock);
        bus_idle();
        bus_address = BASE + 4;
        bus_read_enable = 1;
        @(negedge clock);
        bus_address = BASE + 8;
        checks++;
        if (bus_read_data !== 32'h2) begin errors++; $display("FAIL decode_status: got %h expected 00000002", bus_read_data); end
        @(negedge clock);
        checks++;
        if (bus_read_data !== 32'h0) begin errors++; $display("FAIL decode_unselected_read: got %h expected 0", bus_read_data); end
        bus_idle();
        repeat (60) @(negedge clock);
        checks++;
        if (frames_seen !== base) begin errors++; $display("FAIL decode_no_frame: got %0d frames expected %0d", frames_seen, base); end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        bit stayed_high;
        drive_write(BASE, 32'h00, 4'b0001);
        drive_write(BASE, 32'h3C, 4'b0001);
        bus_release();
        repeat (10) @(negedge clock);
        checks++;
        if (uart_tx !== 1'b0) begin errors++; $display("FAIL midframe_low: got tx %b expected 0", uart_tx); end
        reset = 0;
        #1;
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx: got tx %b expected 1", uart_tx); end
        repeat (3) @(negedge clock);
        reset = 1;
        base = frames_seen;
        @(negedge clock);
        bus_address = BASE + 4;
        bus_read_enable = 1;
        @(negedge clock);
        bus_idle();
        checks++;
        if (bus_read_data !== 32'h2) begin errors++; $display("FAIL post_reset_status: got %h expected 00000002", bus_read_data); end
        stayed_high = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (uart_tx !== 1'b1) stayed_high = 0;
        end
        checks++;
        if (!stayed_high || frames_seen !== base) begin errors++; $display("FAIL post_reset_quiet: got line_high=%b frames=%0d expected 1 and %0d", stayed_high, frames_seen, base); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_overflow();
        test_back_to_back();
        test_decode();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
